// File: rtl/spi_rx_core.sv
// SPI receive deserializer: samples MISO on falling SCLK edges, MSB first, WIDTH bits per frame.
// Optional abort pulse when reception is disabled mid-frame: define SPI_RX_ABORT_FLAG_EN.
module spi_rx_core #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             rx_en_i,
    input  logic             SCLK_i,
    input  logic             MISO_i,
    output logic [WIDTH-1:0] rx_data_o,
`ifdef SPI_RX_ABORT_FLAG_EN
    output logic             abort_o,
`endif
    output logic             rx_done_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic [1:0]       sclk_sync_q;
    logic [1:0]       miso_sync_q;
    logic             sclk_prev_q;
    logic             sclk_fall;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;

    // Equal-depth synchronizers keep MISO aligned with the SCLK edge it belongs to.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sclk_sync_q <= '0;
            miso_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], SCLK_i};
            miso_sync_q <= {miso_sync_q[0], MISO_i};
            sclk_prev_q <= sclk_sync_q[1];
        end
    end

    assign sclk_fall = sclk_prev_q & ~sclk_sync_q[1];

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (!rx_en_i) begin
            count_d = '0;
        end else if (sclk_fall) begin
            shift_d = {shift_q[WIDTH-2:0], miso_sync_q[1]};
            if (count_q == LastCnt) begin
                count_d = '0;
                data_d  = shift_d;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            shift_q <= '0;
            count_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign rx_data_o = data_q;
    assign rx_done_o = done_q;

`ifdef SPI_RX_ABORT_FLAG_EN
    logic abort_q, abort_d;

    // Count is cleared the cycle after rx_en_i drops, so this fires exactly once per abort.
    always_comb begin
        abort_d = !rx_en_i && (count_q != '0);
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= abort_d;
        end
    end

    assign abort_o = abort_q;
`endif

endmodule

// File: tb/tb_spi_rx_core.sv
// Scoreboard bench for spi_rx_core: a 24-bit and an 8-bit instance share SCLK/MISO.
// Define SPI_RX_ABORT_FLAG_EN to also check the abort pulse.
module tb_spi_rx_core;

    localparam int unsigned W = 24;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         rx_en;
    logic         rx_en8;
    logic         sclk;
    logic         miso;
    logic [W-1:0] rx_data;
    logic         rx_done;
    logic [7:0]   rx_data8;
    logic         rx_done8;
`ifdef SPI_RX_ABORT_FLAG_EN
    logic         abort;
    logic         abort8;
`endif

    int           checks = 0;
    int           failures = 0;
    int           done_cnt = 0;
    int           done8_cnt = 0;
    int           abort_cnt = 0;
    logic         done_prev = 1'b0;
    realtime      t_fall = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   exp8_q[$];

    always #5 clock = ~clock;

    spi_rx_core #(.WIDTH(W)) dut (
        .clock_i   (clock),
        .reset_i   (reset_n),
        .rx_en_i   (rx_en),
        .SCLK_i    (sclk),
        .MISO_i    (miso),
        .rx_data_o (rx_data),
`ifdef SPI_RX_ABORT_FLAG_EN
        .abort_o   (abort),
`endif
        .rx_done_o (rx_done)
    );

    spi_rx_core #(.WIDTH(8)) dut8 (
        .clock_i   (clock),
        .reset_i   (reset_n),
        .rx_en_i   (rx_en8),
        .SCLK_i    (sclk),
        .MISO_i    (miso),
        .rx_data_o (rx_data8),
`ifdef SPI_RX_ABORT_FLAG_EN
        .abort_o   (abort8),
`endif
        .rx_done_o (rx_done8)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // MISO changes just after the rising edge; the DUT samples it on the falling edge.
    task automatic send_bit(input logic b);
        sclk = 1'b1;
        #5 miso = b;
        #35 sclk = 1'b0;
        t_fall = $realtime;
        #40;
    endtask

    task automatic send_frame(input logic [63:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            send_bit(word[i]);
        end
    endtask

    task automatic settle();
        repeat (6) @(posedge clock);
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (rx_done) begin
            done_cnt++;
            check_eq("done_width", {63'd0, done_prev}, 64'd0);
            check_eq("done_latency",
                     {63'd0, ($realtime - t_fall >= 20) && ($realtime - t_fall <= 40)}, 64'd1);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 64'd1, 64'd0);
            end else begin
                check_eq("frame24", 64'(rx_data), 64'(exp_q.pop_front()));
            end
        end
        done_prev = rx_done;
        if (rx_done8) begin
            done8_cnt++;
            if (exp8_q.size() == 0) begin
                check_eq("unexpected_done8", 64'd1, 64'd0);
            end else begin
                check_eq("frame8", 64'(rx_data8), 64'(exp8_q.pop_front()));
            end
        end
`ifdef SPI_RX_ABORT_FLAG_EN
        if (abort) abort_cnt++;
        if (abort8) check_eq("abort8_spurious", 64'd1, 64'd0);
`endif
    end

    initial begin
        reset_n = 1'b0;
        rx_en   = 1'b0;
        rx_en8  = 1'b0;
        sclk    = 1'b0;
        miso    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("reset_data", 64'(rx_data), 64'd0);
        check_eq("reset_done", {63'd0, rx_done}, 64'd0);
        reset_n = 1'b1;
        #3;

        // Disabled: a full frame of ones must be ignored.
        send_frame(64'hFFFFFF, 24);
        settle();
        check_eq("dis_done_cnt", 64'(done_cnt), 64'd0);
        check_eq("dis_data", 64'(rx_data), 64'd0);

        // Single frame; misalignment from the disabled frame would corrupt it.
        rx_en = 1'b1;
        exp_q.push_back(24'hAABBCC);
        send_frame(64'hAABBCC, 24);
        settle();
        check_eq("t1_done_cnt", 64'(done_cnt), 64'd1);
        check_eq("t1_data", 64'(rx_data), 64'hAABBCC);
        repeat (20) @(posedge clock);
        @(negedge clock);
        check_eq("t1_hold", 64'(rx_data), 64'hAABBCC);

        // Back-to-back frames.
        exp_q.push_back(24'h123456);
        exp_q.push_back(24'hFEDCBA);
        send_frame(64'h123456, 24);
        send_frame(64'hFEDCBA, 24);
        settle();
        check_eq("t2_done_cnt", 64'(done_cnt), 64'd3);
        check_eq("t2_data", 64'(rx_data), 64'hFEDCBA);

        // Drop enable after 10 bits, then a clean frame.
        send_frame(64'h155, 10);
        @(negedge clock);
        rx_en = 1'b0;
        settle();
        check_eq("t4_partial_done", 64'(done_cnt), 64'd3);
        check_eq("t4_partial_data", 64'(rx_data), 64'hFEDCBA);
`ifdef SPI_RX_ABORT_FLAG_EN
        check_eq("t4_abort_cnt", 64'(abort_cnt), 64'd1);
`endif
        rx_en = 1'b1;
        #3;
        exp_q.push_back(24'h00F00F);
        send_frame(64'h00F00F, 24);
        settle();
        check_eq("t4_done_cnt", 64'(done_cnt), 64'd4);
        check_eq("t4_data", 64'(rx_data), 64'h00F00F);

        // Reset mid-frame.
        send_frame(64'hABC, 12);
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("t5_rst_data", 64'(rx_data), 64'd0);
        check_eq("t5_rst_done", {63'd0, rx_done}, 64'd0);
        reset_n = 1'b1;
        #3;
        exp_q.push_back(24'hA5A5A5);
        send_frame(64'hA5A5A5, 24);
        settle();
        check_eq("t5_done_cnt", 64'(done_cnt), 64'd5);
        check_eq("t5_data", 64'(rx_data), 64'hA5A5A5);

        // 8-bit instance.
        rx_en  = 1'b0;
        rx_en8 = 1'b1;
        #3;
        exp8_q.push_back(8'h81);
        send_frame(64'h81, 8);
        settle();
        check_eq("t6_done8_cnt", 64'(done8_cnt), 64'd1);
        check_eq("t6_data8", 64'(rx_data8), 64'h81);
        check_eq("t6_done24_cnt", 64'(done_cnt), 64'd5);
`ifdef SPI_RX_ABORT_FLAG_EN
        check_eq("final_abort_cnt", 64'(abort_cnt), 64'd1);
`endif

        check_eq("sb_empty24", 64'(exp_q.size()), 64'd0);
        check_eq("sb_empty8", 64'(exp8_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
